// File: rtl/iccm_prog_loader_pkg.sv
// Shared types and constants for the ICCM program loader.
// Holds the loader state encoding and the default end-of-program marker.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } loader_state_e;

  localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes, least significant first, into one 32-bit word.
// word_valid_o pulses combinationally together with the fourth byte.
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_reg;
  logic [1:0]  idx_next;
  logic [23:0] lanes;

  assign idx_next = idx_reg + 2'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_reg <= 2'd0;
    end else if (byte_valid_i) begin
      idx_reg <= idx_next;
    end
  end

  // The top byte lane is never stored: it is taken straight from the input.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          lane_reg <= 8'd0;
        end else if (byte_valid_i && (idx_reg == 2'(gi))) begin
          lane_reg <= byte_data_i;
        end
      end

      assign lanes[gi*8 +: 8] = lane_reg;
    end
  endgenerate

  assign word_valid_o = byte_valid_i && (idx_reg == 2'd3);
  assign word_o       = {byte_data_i, lanes};

endmodule

// File: rtl/iccm_prog_loader.sv
// Streams a little-endian byte program into ICCM until the end marker word.
// Optional trailing checksum check is enabled by defining LOADER_CHECKSUM_EN.
module iccm_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W   = 13,
  parameter logic [31:0] END_WORD = END_WORD_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              iccm_we_o,
  output logic [ADDR_W-1:0] iccm_addr_o,
  output logic [31:0]       iccm_wdata_o,
  output logic              prog_done_o,
  output logic              ovf_err_o,
  output logic              chk_err_o
);

  // One extra count bit so "ICCM completely full" is distinguishable from zero.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  loader_state_e    state_reg;
  loader_state_e    state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      wdata_reg;
  logic             ovf_reg;
  logic             ovf_set;
  logic             accept;
  logic             word_valid;
  logic [31:0]      word;
  logic             is_end;

  assign rx_ready_o = !rst_i && ((state_reg == COLLECT) || (state_reg == CHECK));
  assign accept     = rx_valid_i && rx_ready_o;
  assign is_end     = (word == END_WORD);

  word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_valid_i (accept),
    .byte_data_i  (rx_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_next = state_reg;
    ovf_set    = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (word_valid) begin
          if (is_end) begin
`ifdef LOADER_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = DONE;
`endif
          end else if (cnt_reg == CNT_FULL) begin
            ovf_set    = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WRITE;
          end
        end
      end
      WRITE: state_next = COLLECT;
      CHECK: begin
        if (word_valid) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= COLLECT;
      cnt_reg   <= '0;
      wdata_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == COLLECT) && word_valid) begin
        wdata_reg <= word;
      end
      if (state_reg == WRITE) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_reg;
  logic        chk_reg;

  // The sum follows the words actually written, so an overflowed tail is excluded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_reg <= '0;
      chk_reg <= 1'b0;
    end else begin
      if (state_reg == WRITE) begin
        sum_reg <= sum_reg + wdata_reg;
      end
      if ((state_reg == CHECK) && word_valid && (word != sum_reg)) begin
        chk_reg <= 1'b1;
      end
    end
  end

  assign chk_err_o = chk_reg;
`else
  assign chk_err_o = 1'b0;
`endif

  assign iccm_we_o    = (state_reg == WRITE);
  assign iccm_addr_o  = iccm_we_o ? cnt_reg[ADDR_W-1:0] : '0;
  assign iccm_wdata_o = iccm_we_o ? wdata_reg : '0;
  assign prog_done_o  = (state_reg == DONE);
  assign ovf_err_o    = ovf_reg;

endmodule

// File: doc/iccm_prog_loader.md
ICCM_PROG_LOADER -- requirements
Module: iccm_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, ICCM word-address width (8192 words = 32 KB).
REQ-002 SHALL have parameter END_WORD, default 32'h0000_0FFF, end-of-program marker word.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port rx_valid_i, input, 1, a byte is offered on rx_data_i.
REQ-006 SHALL have port rx_data_i, input, 8, program byte from the serial receiver.
REQ-007 SHALL have port rx_ready_o, output, 1, the loader accepts a byte this cycle.
REQ-008 SHALL have port iccm_we_o, output, 1, ICCM word write strobe.
REQ-009 SHALL have port iccm_addr_o, output, ADDR_W, ICCM word address.
REQ-010 SHALL have port iccm_wdata_o, output, 32, ICCM write data.
REQ-011 SHALL have port prog_done_o, output, 1, load complete; drives prog_done_i of the boot address manager.
REQ-012 SHALL have port ovf_err_o, output, 1, sticky flag: program exceeded ICCM.
REQ-013 SHALL have port chk_err_o, output, 1, sticky flag: checksum mismatch.

Function
REQ-014 SHALL accept a byte only on a cycle where rx_valid_i and rx_ready_o are both 1.
REQ-015 SHALL implement states COLLECT, WRITE, CHECK and DONE, with rx_ready_o = 1 only in COLLECT and CHECK.
REQ-016 SHALL place the k-th accepted byte of a word (k = 0..3) at bits [8k+7:8k] (little-endian).
REQ-017 SHALL, on the 4th byte in COLLECT, enter WRITE if the word != END_WORD; otherwise enter CHECK (macro defined) or DONE (macro undefined).
REQ-018 SHALL, in WRITE, assert iccm_we_o for exactly one cycle (the cycle after the 4th byte), driving the assembled word and the current word count as address.
REQ-019 SHALL increment the word count by 1 after each write and return to COLLECT.
REQ-020 SHALL NOT write END_WORD itself to ICCM.
REQ-021 SHALL, when a non-END word completes after 2^ADDR_W words have been written, set ovf_err_o, suppress the write, and enter DONE (no address wrap).
REQ-022 SHALL hold prog_done_o = 1 and rx_ready_o = 0 in DONE until reset.
REQ-023 SHALL drive iccm_we_o to 0 in every state other than WRITE; iccm_addr_o and iccm_wdata_o are don't-care while iccm_we_o = 0.
REQ-024 SHALL ignore rx_data_i whenever rx_valid_i = 0, with no state change.

Reset
REQ-025 SHALL, while rst_i = 1 at a clock edge, set state COLLECT, byte index 0, word count 0, checksum 0, and drive all outputs 0.
REQ-026 SHALL discard any partially assembled word when rst_i asserts mid-operation, including in WRITE (that write still completes only if it already occurred).

Configuration
REQ-027 SHALL, with LOADER_CHECKSUM_EN defined, keep a 32-bit wrapping sum of all written words and, in CHECK, receive 4 more bytes (little-endian) as the expected sum.
REQ-028 SHALL, with LOADER_CHECKSUM_EN defined, set chk_err_o on mismatch, then enter DONE in the cycle after the 4th checksum byte, with prog_done_o asserting regardless of the result.
REQ-029 SHALL, without LOADER_CHECKSUM_EN, omit the CHECK state and the sum register, and tie chk_err_o to 0.

Structure
REQ-030 SHALL place the state enum type and the default END_WORD constant in the shared package prog_loader_pkg.
REQ-031 SHALL implement byte-to-word assembly (byte index, shift register, word_valid pulse) in sub-module word_assembler, reused for the checksum word.

Verification
REQ-032 SHALL cover: bytes 78 56 34 12, then FF 0F 00 00 -> one write of 32'h1234_5678 at address 0; prog_done_o rises 1 cycle after the last byte.
REQ-033 SHALL cover: 3 words, with rx_valid_i toggling 1/0 every cycle -> writes at addresses 0, 1, 2 with correct data; no byte lost or duplicated.
REQ-034 SHALL cover: ADDR_W = 2, 5 non-END words -> 4 writes (addresses 0..3), ovf_err_o = 1, prog_done_o = 1, no 5th write.
REQ-035 SHALL cover: rst_i pulsed after 2 bytes of a word -> no write; the next 4 bytes form word 0 at address 0.
REQ-036 SHALL cover, with LOADER_CHECKSUM_EN: words 1 and 2, END, checksum 3 -> chk_err_o = 0; checksum 4 -> chk_err_o = 1; prog_done_o = 1 in both cases.
REQ-037 SHALL cover: bytes offered in DONE -> rx_ready_o = 0, no writes, outputs stable.
